// File: rtl/seqdet_param.sv
// Parametrised serial pattern detector with a run-time loadable pattern,
// optional overlapping detection and a saturating match counter.
module seqdet_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_vld,
  input  logic               din,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int            FW   = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_r;
  logic [PAT_LEN-2:0] hist_r;
  logic [FW-1:0]      fill_r;

  logic               accept_s;
  logic               hit_s;
  logic [PAT_LEN-1:0] window_s;
  logic [CNT_W-1:0]   cnt_nxt_s;

  assign cnt_sat = &match_cnt;

  // Hit detection on the incoming bit and next counter value.
  always_comb begin
    accept_s = din_vld & ~pat_load;
    window_s = {hist_r, din};
    if (accept_s && (fill_r == FULL) && (window_s == pat_r)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    // A clear coinciding with a hit still counts that hit.
    if (cnt_clr) begin
      cnt_nxt_s = hit_s ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (hit_s && !cnt_sat) begin
      cnt_nxt_s = match_cnt + CNT_W'(1);
    end else begin
      cnt_nxt_s = match_cnt;
    end
  end

  // Pattern register, history/fill state, match pulse and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= PATTERN;
      hist_r    <= {(PAT_LEN-1){1'b0}};
      fill_r    <= {FW{1'b0}};
      match     <= 1'b0;
      match_cnt <= {CNT_W{1'b0}};
    end else begin
      match     <= hit_s;
      match_cnt <= cnt_nxt_s;
      if (pat_load) begin
        pat_r  <= pat_in;
        fill_r <= {FW{1'b0}};
      end else if (din_vld) begin
        hist_r <= window_s[PAT_LEN-2:0];
        if (hit_s && !OVERLAP) begin
          fill_r <= {FW{1'b0}};
        end else if (fill_r != FULL) begin
          fill_r <= fill_r + FW'(1);
        end else begin
          fill_r <= fill_r;
        end
      end else begin
        hist_r <= hist_r;
        fill_r <= fill_r;
      end
    end
  end

endmodule
